rr_arbiter: RTL
===============

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter PORTS, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per port while others wait; legal range 1..255.
REQ-003 Parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 request  input  PORTS  per-port request level; bit i is port i.
REQ-007 grant  output  PORTS  registered grant vector; one-hot or all-zero.
REQ-008 grant_valid  output  1  registered; high exactly when grant is non-zero.
REQ-009 grant_id  output  ID_W  registered index of the granted port, ID_W = clog2(PORTS); 0 when grant_valid is low.

Function
REQ-010 grant shall never have more than one bit set.
REQ-011 Latency: a request sampled at edge n shall be reflected in grant after edge n; no combinational path from request to any output.
REQ-012 Hold: while the granted port's request stays high and hold_cnt < MAX_HOLD, grant shall remain unchanged and hold_cnt shall increment by 1.
REQ-013 Release: if the granted port's request is low at an edge, a new arbitration shall occur at that same edge, with no idle cycle when other requests are pending.
REQ-014 Expiry: if hold_cnt == MAX_HOLD and any other port requests, arbitration at that edge shall exclude the current port.
REQ-015 Lone holder: if hold_cnt == MAX_HOLD and no other port requests, grant shall remain and hold_cnt shall saturate at MAX_HOLD.
REQ-016 Round-robin search (MODE 0) shall start at pointer ptr and ascend, wrapping from PORTS-1 to 0; the first requesting port wins.
REQ-017 Fixed search (MODE 1) shall start at port 0 and ascend; the first requesting, non-excluded port wins.
REQ-018 On every new grant, ptr shall become (winner+1) mod PORTS, and hold_cnt shall become 1.
REQ-019 If no port requests, the next edge shall clear grant, grant_valid and grant_id to 0 and hold_cnt to 0; ptr shall be unchanged.
REQ-020 Requests on non-granted ports shall have no effect until the next arbitration event.
REQ-021 hold_cnt width shall be clog2(MAX_HOLD+1) bits and shall never wrap.

Reset
REQ-022 Reset assertion shall immediately force grant = 0, grant_valid = 0, grant_id = 0, ptr = 0 and hold_cnt = 0, regardless of clk.
REQ-023 After reset is released, the first arbitration shall occur on the first rising edge with any request high; in MODE 0, search starts from port 0.
REQ-024 Reset asserted mid-grant shall discard all hold and pointer history.

Structure
REQ-025 Package arb_pkg shall hold the MODE_RR = 0 and MODE_FIXED = 1 constants and the clog2 helper.
REQ-026 One combinational sub-module, prio_picker, shall be used; inputs are request vector, start index and exclude mask; outputs are a one-hot winner and a found flag; it shall be shared by both modes.
REQ-027 rr_arbiter shall contain only the state registers: grant, ptr and hold_cnt.

Verification (PORTS=4, MAX_HOLD=4 unless stated)
REQ-028 Assert reset while grant=0100 -> outputs 0 without a clock edge; release, request=1111 -> grant=0001, grant_id=0 after the next edge.
REQ-029 MODE 0, request=1111 held -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then wraps to 0001.
REQ-030 MODE 0, grant=0010, request changes to 1001 -> grant=1000 at the next edge, with no idle cycle.
REQ-031 Lone request=0100 for 10 cycles -> grant=0100 continuously; hold_cnt saturates at 4.
REQ-032 MODE 1, request=0110 -> grant=0010; port 0 asserts after 2 cycles -> port 1 keeps grant until cycle 4, then grant=0001.
REQ-033 request=0000 for 1 cycle -> grant=0000, grant_valid=0 after the edge; a random 32-cycle stream shall hold the one-hot and no-starvation (at most 3*MAX_HOLD wait) assertions.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the request arbiter.
package arb_pkg;

   localparam int unsigned MODE_RR    = 0;
   localparam int unsigned MODE_FIXED = 1;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((33'(1) << i) < 33'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/prio_picker.sv
// Rotating priority picker: the first eligible requester at or after start wins.
module prio_picker
   import arb_pkg::*;
#(
   parameter int unsigned PORTS = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [PORTS-1:0] request,
   input  logic [IDX_W-1:0] start,
   input  logic [PORTS-1:0] exclude,
   output logic [PORTS-1:0] winner,
   output logic             found
);

   logic [PORTS-1:0] eligible;

   assign eligible = request & ~exclude;

   always_comb begin
      int unsigned idx;
      winner = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         idx = 32'(start) + i;
         if (idx >= PORTS) idx = idx - PORTS;
         if (!found && eligible[IDX_W'(idx)]) begin
            winner[IDX_W'(idx)] = 1'b1;
            found               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Request arbiter with per-grant hold limit; round-robin or fixed priority.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned PORTS    = 4,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned MODE     = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PORTS-1:0]          request,
   output logic [PORTS-1:0]          grant,
   output logic                      grant_valid,
   output logic [clog2(PORTS)-1:0]   grant_id
);

   localparam int unsigned ID_W   = clog2(PORTS);
   localparam int unsigned HOLD_W = clog2(MAX_HOLD + 1);

   logic [ID_W-1:0]   ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic              cur_req;
   logic              others;
   logic              expired;
   logic              keep;
   logic [PORTS-1:0]  exclude;
   logic [ID_W-1:0]   start;
   logic [PORTS-1:0]  winner;
   logic              found;
   logic [ID_W-1:0]   winner_id;
   logic [ID_W-1:0]   ptr_next;

   assign cur_req = |(request & grant);
   assign others  = |(request & ~grant);
   assign expired = (hold_cnt == HOLD_W'(MAX_HOLD));
   // Holder keeps the grant until its limit, or beyond it if nobody else is waiting.
   assign keep    = cur_req && (!expired || !others);
   assign exclude = (cur_req && expired) ? grant : '0;
   assign start   = (MODE == MODE_FIXED) ? '0 : ptr;

   prio_picker #(
      .PORTS (PORTS),
      .IDX_W (ID_W)
   ) u_picker (
      .request (request),
      .start   (start),
      .exclude (exclude),
      .winner  (winner),
      .found   (found)
   );

   always_comb begin
      winner_id = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         if (winner[i]) winner_id = ID_W'(i);
      end
   end

   assign ptr_next = (winner_id == ID_W'(PORTS - 1)) ? '0 : winner_id + ID_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant    <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else if (keep) begin
         if (!expired) hold_cnt <= hold_cnt + HOLD_W'(1);
      end else if (found) begin
         grant    <= winner;
         ptr      <= ptr_next;
         hold_cnt <= HOLD_W'(1);
      end else begin
         grant    <= '0;
         hold_cnt <= '0;
      end
   end

   // Status outputs decode the grant register only, so they carry no request path.
   assign grant_valid = |grant;

   always_comb begin
      grant_id = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         if (grant[i]) grant_id = ID_W'(i);
      end
   end

endmodule
